simon_engine: RTL and testbench
===============================

// Module: simon_engine
// PURPOSE
//   Self-contained Simon game engine: merges the game FSM with its datapath
//   (pattern memory, write/read counters, playback timer, comparator).
//   Player enters a pattern, engine replays all stored patterns, player repeats them.
//   Sits between debounced switch/button inputs and the board LEDs.
//   Generalises the fixed-width game to PAT_W-bit patterns, DEPTH levels,
//   timed playback and an explicit win/lose outcome.
// PARAMETERS
//   PAT_W         4    pattern width (switches / pattern LEDs)
//   DEPTH         16   max stored patterns; filling all DEPTH = win
//   PLAY_TICKS    2    cycles each entry is shown during PLAYBACK (>=1)
//   TIMEOUT_TICKS 64   REPEAT idle limit (used only with SIMON_TIMEOUT_EN)
// PORTS
//   clk          in   1      clock, all logic on posedge
//   rst          in   1      synchronous, active-low reset
//   pattern_in   in   PAT_W  current switch pattern
//   valid_in     in   1      one-cycle pulse: submit pattern_in
//   pattern_leds out  PAT_W  pattern shown to player
//   mode_leds    out  3      001 INPUT, 010 PLAYBACK, 100 REPEAT, 111 DONE
//   level        out  CW     stored entry count n, CW=$clog2(DEPTH+1)
//   win          out  1      high in DONE after all DEPTH entries repeated correctly
//   lose         out  1      high in DONE after mismatch (or timeout)
// BEHAVIOUR
//   - Reset (rst==0 at posedge): state=INPUT, n=0, rd=0, tick=0, win=lose=0.
//     Mid-operation reset: same, from any state. Memory contents not cleared.
//   - Outputs registered-state Moore; pattern_leds combinational from state.
//   - INPUT: pattern_leds=pattern_in. On valid_in: mem[n]<=pattern_in, n<=n+1,
//     rd<=0, tick<=0, -> PLAYBACK on next cycle.
//   - PLAYBACK: pattern_leds=mem[rd]; valid_in ignored. tick counts 0..PLAY_TICKS-1.
//     At tick==PLAY_TICKS-1: if rd==n-1 -> REPEAT, rd<=0; else rd<=rd+1, tick<=0.
//     Total PLAYBACK duration = n*PLAY_TICKS cycles.
//   - REPEAT: pattern_leds=pattern_in. On valid_in:
//       pattern_in!=mem[rd]               -> DONE, lose<=1
//       match, rd<n-1                     -> rd<=rd+1
//       match, rd==n-1, n<DEPTH           -> INPUT
//       match, rd==n-1, n==DEPTH          -> DONE, win<=1
//     No valid_in: hold.
//   - DONE: loops playback of mem[0..n-1], PLAY_TICKS each, rd wraps to 0;
//     win/lose held; valid_in ignored; exit only by reset.
//   - n saturates at DEPTH (never wraps); INPUT is never entered with n==DEPTH.
//   - win and lose are mutually exclusive; both 0 outside DONE.
//   - level=n at all times; updates the cycle after the INPUT write.
//   - Memory: DEPTH x PAT_W regs, one write port, one async read port at rd.
// CONFIGURATION
//   SIMON_TIMEOUT_EN defined: REPEAT keeps an idle counter, cleared on entry
//     and on every valid_in; reaching TIMEOUT_TICKS cycles w/o valid_in ->
//     DONE, lose<=1.
//   Not defined: no idle counter; REPEAT waits indefinitely.
// TESTING (PAT_W=4, DEPTH=4, PLAY_TICKS=2, TIMEOUT_TICKS=8)
//   1. rst=0 for 2 cycles in any state -> mode_leds=001, level=0, win=lose=0.
//   2. Enter 4'hA -> PLAYBACK shows A for 2 cycles, then REPEAT; submit A ->
//      INPUT, level=1.
//   3. Levels A,5,C: PLAYBACK shows A,A,5,5,C,C; repeat A,5,3 -> DONE,
//      lose=1, mode_leds=111, DONE loops A,5,C.
//   4. Full game A,5,C,F all repeated correctly -> DONE, win=1, level=4;
//      valid_in in DONE ignored.
//   5. valid_in pulsed during PLAYBACK -> no memory write, level unchanged,
//      PLAYBACK timing unchanged.
//   6. SIMON_TIMEOUT_EN: REPEAT idle 8 cycles -> DONE, lose=1; undefined:
//      still REPEAT after 100 cycles.

Source files
------------

// File: rtl/simon_engine.sv
// simon_engine: Simon game engine (FSM + pattern memory, counters, playback timer).
// Optional feature macro: SIMON_TIMEOUT_EN -- REPEAT gives up (lose) after
// TIMEOUT_TICKS idle cycles; without it REPEAT waits indefinitely.
module simon_engine #(
  parameter int PAT_W         = 4,
  parameter int DEPTH         = 16,
  parameter int PLAY_TICKS    = 2,
  parameter int TIMEOUT_TICKS = 64,
  localparam int CW           = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PAT_W-1:0] pattern_in,
  input  logic             valid_in,
  output logic [PAT_W-1:0] pattern_leds,
  output logic [2:0]       mode_leds,
  output logic [CW-1:0]    level,
  output logic             win,
  output logic             lose
);

  localparam int RW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = (PLAY_TICKS > 1) ? $clog2(PLAY_TICKS) : 1;

  // Reject nonsensical configurations at elaboration time.
  generate
    if (DEPTH < 1 || PLAY_TICKS < 1 || TIMEOUT_TICKS < 1) begin : g_bad_param
      $error("simon_engine: DEPTH, PLAY_TICKS and TIMEOUT_TICKS must be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_INPUT  = 2'd0,
    S_PLAY   = 2'd1,
    S_REPEAT = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t            state, state_d;
  logic [CW-1:0]     n, n_d;
  logic [RW-1:0]     rd, rd_d;
  logic [TW-1:0]     tick, tick_d;
  logic              win_d, lose_d;
  logic              mem_we;
  logic [PAT_W-1:0]  mem [DEPTH];
  logic [PAT_W-1:0]  mem_rd;
  logic              rd_last, tick_last;

`ifdef SIMON_TIMEOUT_EN
  localparam int IW = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;
  logic [IW-1:0]     idle, idle_d;
`endif

  assign mem_rd    = mem[rd];
  assign rd_last   = (CW'(rd) == n - CW'(1));
  assign tick_last = (tick == TW'(PLAY_TICKS - 1));
  assign level     = n;

  // Next-state and datapath updates; everything holds unless a case moves it.
  always_comb begin
    state_d = state;
    n_d     = n;
    rd_d    = rd;
    tick_d  = tick;
    win_d   = win;
    lose_d  = lose;
    mem_we  = 1'b0;
`ifdef SIMON_TIMEOUT_EN
    idle_d  = idle;
`endif
    unique case (state)
      S_INPUT: begin
        // n never reaches DEPTH here, but the guard keeps n saturating.
        if (valid_in && n != CW'(DEPTH)) begin
          mem_we  = 1'b1;
          n_d     = n + CW'(1);
          rd_d    = '0;
          tick_d  = '0;
          state_d = S_PLAY;
        end
      end
      // PLAYBACK runs the list once; DONE reuses the same walk but wraps forever.
      S_PLAY, S_DONE: begin
        if (tick_last) begin
          tick_d = '0;
          if (rd_last) begin
            rd_d = '0;
            if (state == S_PLAY) begin
              state_d = S_REPEAT;
`ifdef SIMON_TIMEOUT_EN
              idle_d  = '0;
`endif
            end
          end else begin
            rd_d = rd + RW'(1);
          end
        end else begin
          tick_d = tick + TW'(1);
        end
      end
      S_REPEAT: begin
        if (valid_in) begin
`ifdef SIMON_TIMEOUT_EN
          idle_d = '0;
`endif
          if (pattern_in != mem_rd) begin
            state_d = S_DONE;
            lose_d  = 1'b1;
            rd_d    = '0;
            tick_d  = '0;
          end else if (!rd_last) begin
            rd_d = rd + RW'(1);
          end else if (n == CW'(DEPTH)) begin
            state_d = S_DONE;
            win_d   = 1'b1;
            rd_d    = '0;
            tick_d  = '0;
          end else begin
            state_d = S_INPUT;
          end
        end
`ifdef SIMON_TIMEOUT_EN
        else if (idle == IW'(TIMEOUT_TICKS - 1)) begin
          state_d = S_DONE;
          lose_d  = 1'b1;
          rd_d    = '0;
          tick_d  = '0;
        end else begin
          idle_d = idle + IW'(1);
        end
`endif
      end
      default: state_d = S_INPUT;
    endcase
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_INPUT;
      n     <= '0;
      rd    <= '0;
      tick  <= '0;
      win   <= 1'b0;
      lose  <= 1'b0;
`ifdef SIMON_TIMEOUT_EN
      idle  <= '0;
`endif
    end else begin
      state <= state_d;
      n     <= n_d;
      rd    <= rd_d;
      tick  <= tick_d;
      win   <= win_d;
      lose  <= lose_d;
`ifdef SIMON_TIMEOUT_EN
      idle  <= idle_d;
`endif
    end
  end

  // Pattern memory write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (rst && mem_we) mem[n[RW-1:0]] <= pattern_in;
  end

  // Pattern LEDs follow the switches while the player acts, memory otherwise.
  always_comb begin
    pattern_leds = pattern_in;
    if (state == S_PLAY || state == S_DONE) pattern_leds = mem_rd;
  end

  // Mode LEDs decode the state one-hot, all-on in DONE.
  always_comb begin
    mode_leds = 3'b001;
    unique case (state)
      S_INPUT:  mode_leds = 3'b001;
      S_PLAY:   mode_leds = 3'b010;
      S_REPEAT: mode_leds = 3'b100;
      S_DONE:   mode_leds = 3'b111;
      default:  mode_leds = 3'b001;
    endcase
  end

endmodule

// File: tb/tb_simon_engine.sv
// tb_simon_engine: table-driven directed test of simon_engine
// (PAT_W=4, DEPTH=4, PLAY_TICKS=2, TIMEOUT_TICKS=8).
module tb_simon_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] pattern_in = '0;
  logic       valid_in = 1'b0;
  logic [3:0] pattern_leds;
  logic [2:0] mode_leds;
  logic [2:0] level;
  logic       win, lose;

  int total = 0;
  int bad   = 0;

  simon_engine #(.PAT_W(4), .DEPTH(4), .PLAY_TICKS(2), .TIMEOUT_TICKS(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .pattern_in   (pattern_in),
    .valid_in     (valid_in),
    .pattern_leds (pattern_leds),
    .mode_leds    (mode_leds),
    .level        (level),
    .win          (win),
    .lose         (lose)
  );

  always #5 clk = ~clk;

  // One row = inputs for one cycle plus the outputs expected during that cycle.
  typedef struct {
    logic       v;
    logic [3:0] p;
    logic [3:0] leds;
    logic [2:0] mode;
    logic [2:0] lvl;
    logic       w;
    logic       l;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic v, input logic [3:0] p, input logic [3:0] leds,
                              input logic [2:0] mode, input logic [2:0] lvl,
                              input logic w, input logic l);
    vec_t r;
    r.v = v; r.p = p; r.leds = leds; r.mode = mode; r.lvl = lvl; r.w = w; r.l = l;
    tbl.push_back(r);
  endfunction

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row=%0d got=%h want=%h", name, idx, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int idx, input logic [3:0] leds,
                            input logic [2:0] mode, input logic [2:0] lvl,
                            input logic w, input logic l);
    chk({tag, ".leds"}, idx, {4'h0, pattern_leds}, {4'h0, leds});
    chk({tag, ".mode"}, idx, {5'h0, mode_leds}, {5'h0, mode});
    chk({tag, ".level"}, idx, {5'h0, level}, {5'h0, lvl});
    chk({tag, ".win"}, idx, {7'h0, win}, {7'h0, w});
    chk({tag, ".lose"}, idx, {7'h0, lose}, {7'h0, l});
  endtask

  // Two cycles of reset, then check the idle INPUT state.
  task automatic do_reset(input int idx);
    @(negedge clk);
    rst = 1'b0; valid_in = 1'b0; pattern_in = 4'h0;
    repeat (2) @(negedge clk);
    #1;
    check_outs("reset", idx, 4'h0, 3'b001, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic run_rows(input string tag, input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      @(negedge clk);
      rst = 1'b1; valid_in = tbl[i].v; pattern_in = tbl[i].p;
      #1;
      check_outs(tag, i, tbl[i].leds, tbl[i].mode, tbl[i].lvl, tbl[i].w, tbl[i].l);
    end
  endtask

  initial begin
    int t1_end, t2_end;

    // Levels A,5,C then a wrong repeat (A,5,3) -> lose; valid during PLAYBACK ignored.
    add(1, 4'hA, 4'hA, 3'b001, 3'd0, 0, 0);
    add(0, 4'h0, 4'hA, 3'b010, 3'd1, 0, 0);
    add(0, 4'h0, 4'hA, 3'b010, 3'd1, 0, 0);
    add(1, 4'hA, 4'hA, 3'b100, 3'd1, 0, 0);
    add(1, 4'h5, 4'h5, 3'b001, 3'd1, 0, 0);
    add(0, 4'h0, 4'hA, 3'b010, 3'd2, 0, 0);
    add(0, 4'h0, 4'hA, 3'b010, 3'd2, 0, 0);
    add(0, 4'h0, 4'h5, 3'b010, 3'd2, 0, 0);
    add(0, 4'h0, 4'h5, 3'b010, 3'd2, 0, 0);
    add(1, 4'hA, 4'hA, 3'b100, 3'd2, 0, 0);
    add(1, 4'h5, 4'h5, 3'b100, 3'd2, 0, 0);
    add(1, 4'hC, 4'hC, 3'b001, 3'd2, 0, 0);
    add(0, 4'h0, 4'hA, 3'b010, 3'd3, 0, 0);
    add(1, 4'hF, 4'hA, 3'b010, 3'd3, 0, 0);
    add(0, 4'h0, 4'h5, 3'b010, 3'd3, 0, 0);
    add(1, 4'hF, 4'h5, 3'b010, 3'd3, 0, 0);
    add(0, 4'h0, 4'hC, 3'b010, 3'd3, 0, 0);
    add(0, 4'h0, 4'hC, 3'b010, 3'd3, 0, 0);
    add(1, 4'hA, 4'hA, 3'b100, 3'd3, 0, 0);
    add(1, 4'h5, 4'h5, 3'b100, 3'd3, 0, 0);
    add(1, 4'h3, 4'h3, 3'b100, 3'd3, 0, 0);
    add(0, 4'h0, 4'hA, 3'b111, 3'd3, 0, 1);
    add(0, 4'h0, 4'hA, 3'b111, 3'd3, 0, 1);
    add(0, 4'h0, 4'h5, 3'b111, 3'd3, 0, 1);
    add(1, 4'hF, 4'h5, 3'b111, 3'd3, 0, 1);
    add(0, 4'h0, 4'hC, 3'b111, 3'd3, 0, 1);
    add(0, 4'h0, 4'hC, 3'b111, 3'd3, 0, 1);
    add(0, 4'h0, 4'hA, 3'b111, 3'd3, 0, 1);
    add(0, 4'h0, 4'hA, 3'b111, 3'd3, 0, 1);
    t1_end = tbl.size();

    // Full game A,5,C,F repeated correctly -> win at level 4; DONE ignores valid.
    add(1, 4'hA, 4'hA, 3'b001, 3'd0, 0, 0);
    add(0, 4'h0, 4'hA, 3'b010, 3'd1, 0, 0);
    add(0, 4'h0, 4'hA, 3'b010, 3'd1, 0, 0);
    add(1, 4'hA, 4'hA, 3'b100, 3'd1, 0, 0);
    add(1, 4'h5, 4'h5, 3'b001, 3'd1, 0, 0);
    add(0, 4'h0, 4'hA, 3'b010, 3'd2, 0, 0);
    add(0, 4'h0, 4'hA, 3'b010, 3'd2, 0, 0);
    add(0, 4'h0, 4'h5, 3'b010, 3'd2, 0, 0);
    add(0, 4'h0, 4'h5, 3'b010, 3'd2, 0, 0);
    add(1, 4'hA, 4'hA, 3'b100, 3'd2, 0, 0);
    add(1, 4'h5, 4'h5, 3'b100, 3'd2, 0, 0);
    add(1, 4'hC, 4'hC, 3'b001, 3'd2, 0, 0);
    add(0, 4'h0, 4'hA, 3'b010, 3'd3, 0, 0);
    add(0, 4'h0, 4'hA, 3'b010, 3'd3, 0, 0);
    add(0, 4'h0, 4'h5, 3'b010, 3'd3, 0, 0);
    add(0, 4'h0, 4'h5, 3'b010, 3'd3, 0, 0);
    add(0, 4'h0, 4'hC, 3'b010, 3'd3, 0, 0);
    add(0, 4'h0, 4'hC, 3'b010, 3'd3, 0, 0);
    add(1, 4'hA, 4'hA, 3'b100, 3'd3, 0, 0);
    add(1, 4'h5, 4'h5, 3'b100, 3'd3, 0, 0);
    add(1, 4'hC, 4'hC, 3'b100, 3'd3, 0, 0);
    add(1, 4'hF, 4'hF, 3'b001, 3'd3, 0, 0);
    add(0, 4'h0, 4'hA, 3'b010, 3'd4, 0, 0);
    add(0, 4'h0, 4'hA, 3'b010, 3'd4, 0, 0);
    add(0, 4'h0, 4'h5, 3'b010, 3'd4, 0, 0);
    add(0, 4'h0, 4'h5, 3'b010, 3'd4, 0, 0);
    add(0, 4'h0, 4'hC, 3'b010, 3'd4, 0, 0);
    add(0, 4'h0, 4'hC, 3'b010, 3'd4, 0, 0);
    add(0, 4'h0, 4'hF, 3'b010, 3'd4, 0, 0);
    add(0, 4'h0, 4'hF, 3'b010, 3'd4, 0, 0);
    add(1, 4'hA, 4'hA, 3'b100, 3'd4, 0, 0);
    add(1, 4'h5, 4'h5, 3'b100, 3'd4, 0, 0);
    add(1, 4'hC, 4'hC, 3'b100, 3'd4, 0, 0);
    add(1, 4'hF, 4'hF, 3'b100, 3'd4, 0, 0);
    add(1, 4'h3, 4'hA, 3'b111, 3'd4, 1, 0);
    add(0, 4'h0, 4'hA, 3'b111, 3'd4, 1, 0);
    add(0, 4'h0, 4'h5, 3'b111, 3'd4, 1, 0);
    add(1, 4'h0, 4'h5, 3'b111, 3'd4, 1, 0);
    add(0, 4'h0, 4'hC, 3'b111, 3'd4, 1, 0);
    add(0, 4'h0, 4'hC, 3'b111, 3'd4, 1, 0);
    add(0, 4'h0, 4'hF, 3'b111, 3'd4, 1, 0);
    add(0, 4'h0, 4'hF, 3'b111, 3'd4, 1, 0);
    add(0, 4'h0, 4'hA, 3'b111, 3'd4, 1, 0);
    t2_end = tbl.size();

    do_reset(0);
    run_rows("lose_game", 0, t1_end);
    do_reset(1);            // reset out of DONE/lose
    run_rows("win_game", t1_end, t2_end);
    do_reset(2);            // reset out of DONE/win

    // Reset in the middle of PLAYBACK.
    @(negedge clk); rst = 1'b1; valid_in = 1'b1; pattern_in = 4'h6;
    @(negedge clk); valid_in = 1'b0; pattern_in = 4'h0;
    #1;
    check_outs("mid_play", 0, 4'h6, 3'b010, 3'd1, 1'b0, 1'b0);
    do_reset(3);

    // REPEAT idle behaviour: enter 9, let PLAYBACK finish, then stay idle.
    @(negedge clk); rst = 1'b1; valid_in = 1'b1; pattern_in = 4'h9;
    @(negedge clk); valid_in = 1'b0; pattern_in = 4'h0;
    @(negedge clk);
    @(negedge clk); #1;
    check_outs("rep_entry", 0, 4'h0, 3'b100, 3'd1, 1'b0, 1'b0);
`ifdef SIMON_TIMEOUT_EN
    repeat (7) @(negedge clk);
    #1;
    check_outs("idle7", 0, 4'h0, 3'b100, 3'd1, 1'b0, 1'b0);
    @(negedge clk); #1;
    check_outs("timeout", 0, 4'h9, 3'b111, 3'd1, 1'b0, 1'b1);
`else
    repeat (100) @(negedge clk);
    #1;
    check_outs("no_timeout", 0, 4'h0, 3'b100, 3'd1, 1'b0, 1'b0);
    // A late correct answer still advances the game.
    @(negedge clk); valid_in = 1'b1; pattern_in = 4'h9;
    @(negedge clk); valid_in = 1'b0; pattern_in = 4'h2; #1;
    check_outs("late_ok", 0, 4'h2, 3'b001, 3'd1, 1'b0, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
